// File: rtl/reg_arbiter.sv
// Round-robin arbitrated shared register: one requester writes per cycle.
// Optional ownership lock (IDLE/OWNED FSM + timer) compiled in with REG_ARB_LOCK_EN.
module reg_arbiter #(
    parameter int N        = 64,
    parameter int NREQ     = 4,
    parameter int LOCK_MAX = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         lock,
    input  logic [NREQ*N-1:0]       wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [N-1:0]            q,
    output logic [$clog2(NREQ)-1:0] last_id,
    output logic [15:0]             wr_cnt,
    output logic                    locked
);
    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] ptr;
    logic [IW-1:0] rr_win;
    logic [IW-1:0] idx;
    logic [IW-1:0] wid;
    logic          rr_found;
    logic          wen;

    function automatic logic [IW-1:0] next_id(input logic [IW-1:0] i);
        return (i == IW'(NREQ - 1)) ? '0 : i + IW'(1);
    endfunction

    // Walk from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        rr_win   = '0;
        rr_found = 1'b0;
        idx      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (req[idx]) begin
                rr_win   = idx;
                rr_found = 1'b1;
            end
        end
    end

`ifdef REG_ARB_LOCK_EN
    localparam int TW = $clog2(LOCK_MAX + 1);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t        state;
    logic [IW-1:0] owner;
    logic [TW-1:0] timer;
    logic          release_now;

    assign release_now = !req[owner] || !lock[owner] || (timer == TW'(LOCK_MAX));

    always_comb begin
        gnt = '0;
        wid = rr_win;
        if (state == OWNED) begin
            wid = owner;
            if (req[owner] && !reset) gnt[owner] = 1'b1;
        end else if (rr_found && !reset) begin
            gnt[rr_win] = 1'b1;
        end
    end

    assign locked = (state == OWNED) && !reset;
`else
    logic unused;

    always_comb begin
        gnt = '0;
        wid = rr_win;
        if (rr_found && !reset) gnt[rr_win] = 1'b1;
    end

    assign locked = 1'b0;
    assign unused = ^lock ^ (LOCK_MAX > 0);
`endif

    assign wen = |gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            q       <= '0;
            ptr     <= '0;
            last_id <= '0;
            wr_cnt  <= '0;
`ifdef REG_ARB_LOCK_EN
            state   <= IDLE;
            owner   <= '0;
            timer   <= '0;
`endif
        end else begin
            if (wen) begin
                q       <= wdata[int'(wid)*N +: N];
                last_id <= wid;
                if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
            end
`ifdef REG_ARB_LOCK_EN
            case (state)
                IDLE: begin
                    if (wen && lock[wid]) begin
                        state <= OWNED;
                        owner <= wid;
                        timer <= TW'(1);
                    end else if (wen) begin
                        ptr <= next_id(wid);
                    end
                end
                OWNED: begin
                    // Release advances ptr past the owner so it cannot re-grab immediately.
                    if (release_now) begin
                        state <= IDLE;
                        timer <= '0;
                        ptr   <= next_id(owner);
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
`else
            if (wen) ptr <= next_id(wid);
`endif
        end
    end
endmodule

// File: tb/tb_reg_arbiter.sv
// Scoreboard bench for reg_arbiter: expected grant/q/id queued at drive time, popped after the edge.
module tb_reg_arbiter;
    localparam int N    = 64;
    localparam int NREQ = 4;
    localparam int IW   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   lock;
    logic [NREQ*N-1:0] wdata;
    logic [NREQ-1:0]   gnt;
    logic [N-1:0]      q;
    logic [IW-1:0]     last_id;
    logic [15:0]       wr_cnt;
    logic              locked;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic [N-1:0]    q;
        logic [IW-1:0]   id;
    } exp_t;

    exp_t sb[$];

    reg_arbiter #(.N(N), .NREQ(NREQ), .LOCK_MAX(16)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .wdata(wdata),
        .gnt(gnt), .q(q), .last_id(last_id), .wr_cnt(wr_cnt), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'hF;
        wdata = {64'd4, 64'd3, 64'd2, 64'd1};
        for (int c = 0; c < 2; c++) begin
            #3;
            checks++;
            if (gnt !== 4'b0 || locked !== 1'b0) begin
                errors++;
                $display("FAIL reset_gnt cycle %0d: got gnt=%b locked=%b want 0000/0", c, gnt, locked);
            end
            tick();
            checks++;
            if (q !== 64'd0 || wr_cnt !== 16'd0 || last_id !== 2'd0) begin
                errors++;
                $display("FAIL reset_regs cycle %0d: got q=%h cnt=%0d id=%0d want 0/0/0", c, q, wr_cnt, last_id);
            end
        end
        reset = 1'b0;
        req   = 4'h0;
    endtask

    task automatic test_round_robin();
        exp_t e;
        wdata = {64'd4, 64'd3, 64'd2, 64'd1};
        req   = 4'hF;
        for (int c = 0; c < 8; c++) begin
            sb.push_back('{gnt: 4'b0001 << (c % 4), q: 64'(c % 4 + 1), id: 2'(c % 4)});
            #3;
            e = sb[0];
            checks++;
            if (gnt !== e.gnt) begin
                errors++;
                $display("FAIL rr_gnt cycle %0d: got %b want %b", c, gnt, e.gnt);
            end
            tick();
            e = sb.pop_front();
            checks++;
            if (q !== e.q || last_id !== e.id) begin
                errors++;
                $display("FAIL rr_q cycle %0d: got q=%h id=%0d want q=%h id=%0d", c, q, last_id, e.q, e.id);
            end
        end
        req = 4'h0;
        checks++;
        if (wr_cnt !== 16'd8) begin
            errors++;
            $display("FAIL rr_cnt: got %0d want 8", wr_cnt);
        end
    endtask

    task automatic test_wrap_skip();
        logic [NREQ-1:0] stim [4] = '{4'b0100, 4'b0101, 4'b0101, 4'b0000};
        logic [NREQ-1:0] eg   [4] = '{4'b0100, 4'b0001, 4'b0100, 4'b0000};
        logic [N-1:0]    eq   [4] = '{64'h30, 64'h10, 64'h30, 64'h30};
        logic [IW-1:0]   ei   [4] = '{2'd2, 2'd0, 2'd2, 2'd2};
        exp_t e;
        wdata = {64'h40, 64'h30, 64'h20, 64'h10};
        for (int c = 0; c < 4; c++) begin
            req = stim[c];
            sb.push_back('{gnt: eg[c], q: eq[c], id: ei[c]});
            #3;
            e = sb[0];
            checks++;
            if (gnt !== e.gnt) begin
                errors++;
                $display("FAIL wrap_gnt step %0d: got %b want %b", c, gnt, e.gnt);
            end
            tick();
            e = sb.pop_front();
            checks++;
            if (q !== e.q || last_id !== e.id) begin
                errors++;
                $display("FAIL wrap_q step %0d: got q=%h id=%0d want q=%h id=%0d", c, q, last_id, e.q, e.id);
            end
        end
        checks++;
        if (wr_cnt !== 16'd11) begin
            errors++;
            $display("FAIL wrap_cnt: got %0d want 11", wr_cnt);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [N-1:0] v;
        req = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            v = {$urandom, $urandom};
            wdata[N +: N] = v;
            sb.push_back('{gnt: 4'b0010, q: v, id: 2'd1});
            #3;
            e = sb[0];
            checks++;
            if (gnt !== e.gnt) begin
                errors++;
                $display("FAIL b2b_gnt cycle %0d: got %b want %b", c, gnt, e.gnt);
            end
            tick();
            e = sb.pop_front();
            checks++;
            if (q !== e.q || last_id !== e.id) begin
                errors++;
                $display("FAIL b2b_q cycle %0d: got q=%h id=%0d want q=%h id=%0d", c, q, last_id, e.q, e.id);
            end
        end
        req = 4'h0;
        checks++;
        if (wr_cnt !== 16'd14) begin
            errors++;
            $display("FAIL b2b_cnt: got %0d want 14", wr_cnt);
        end
    endtask

    task automatic test_reset_mid();
        wdata = {64'd4, 64'd3, 64'd2, 64'd1};
        req   = 4'hF;
        tick();
        tick();
        reset = 1'b1;
        #3;
        checks++;
        if (gnt !== 4'b0) begin
            errors++;
            $display("FAIL rstmid_gnt: got %b want 0000", gnt);
        end
        tick();
        reset = 1'b0;
        checks++;
        if (q !== 64'd0 || wr_cnt !== 16'd0 || last_id !== 2'd0) begin
            errors++;
            $display("FAIL rstmid_regs: got q=%h cnt=%0d id=%0d want 0/0/0", q, wr_cnt, last_id);
        end
        #3;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid_ptr: got gnt=%b want 0001", gnt);
        end
        tick();
        req = 4'h0;
        tick();
    endtask

`ifdef REG_ARB_LOCK_EN
    task automatic test_lock();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wdata = {64'd4, 64'd3, 64'd2, 64'd1};
        req   = 4'hF;
        lock  = 4'b0001;
        #3;
        checks++;
        if (gnt !== 4'b0001 || locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_first: got gnt=%b locked=%b want 0001/0", gnt, locked);
        end
        tick();
        for (int t = 1; t <= 16; t++) begin
            #3;
            checks++;
            if (gnt !== 4'b0001 || locked !== 1'b1) begin
                errors++;
                $display("FAIL lock_owned t=%0d: got gnt=%b locked=%b want 0001/1", t, gnt, locked);
            end
            tick();
        end
        #3;
        checks++;
        if (gnt !== 4'b0010 || locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_release: got gnt=%b locked=%b want 0010/0", gnt, locked);
        end
        tick();
        checks++;
        if (q !== 64'd2 || last_id !== 2'd1) begin
            errors++;
            $display("FAIL lock_handoff_q: got q=%h id=%0d want 2/1", q, last_id);
        end
        req  = 4'h0;
        lock = 4'h0;
        tick();
    endtask

    task automatic test_reset_mid_lock();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wdata = {64'd4, 64'd3, 64'd2, 64'hAAAA};
        req   = 4'hF;
        lock  = 4'b0001;
        for (int c = 0; c < 5; c++) tick();
        wdata[N-1:0] = 64'h5555;
        reset = 1'b1;
        #3;
        checks++;
        if (gnt !== 4'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL lockrst_cycle: got gnt=%b locked=%b want 0000/0", gnt, locked);
        end
        tick();
        reset = 1'b0;
        lock  = 4'h0;
        checks++;
        if (locked !== 1'b0 || q !== 64'd0 || wr_cnt !== 16'd0) begin
            errors++;
            $display("FAIL lockrst_after: got locked=%b q=%h cnt=%0d want 0/0/0", locked, q, wr_cnt);
        end
        #3;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL lockrst_ptr: got gnt=%b want 0001", gnt);
        end
        tick();
        req = 4'h0;
        tick();
    endtask
`endif

    task automatic test_saturation();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wdata = '0;
        req   = 4'b0001;
        for (int k = 0; k < 65537; k++) begin
            wdata[N-1:0] = 64'(k);
            tick();
            if (k == 65533) begin
                checks++;
                if (wr_cnt !== 16'hFFFE) begin
                    errors++;
                    $display("FAIL sat_pre: got %h want fffe", wr_cnt);
                end
            end
            if (k == 65534) begin
                checks++;
                if (wr_cnt !== 16'hFFFF) begin
                    errors++;
                    $display("FAIL sat_hit: got %h want ffff", wr_cnt);
                end
            end
        end
        req = 4'h0;
        checks++;
        if (wr_cnt !== 16'hFFFF || q !== 64'd65536) begin
            errors++;
            $display("FAIL sat_end: got cnt=%h q=%h want ffff/10000", wr_cnt, q);
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        lock  = '0;
        wdata = '0;
        test_reset();
        test_round_robin();
        test_wrap_skip();
        test_back_to_back();
        test_reset_mid();
`ifdef REG_ARB_LOCK_EN
        test_lock();
        test_reset_mid_lock();
`endif
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
